// File: rtl/shift_sequencer.sv
// Multi-cycle controller that drives a 1-bit combinational shifter, feeding its output
// back each clock until the requested shift amount has been applied.
module shift_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             dir,
    input  logic [CNT_W-1:0] amount,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] sh_B,
    output logic [1:0]       sh_Hselect,
    input  logic [WIDTH-1:0] sh_H
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             dir_q;

    localparam logic [1:0] HSEL_PASS  = 2'b00;
    localparam logic [1:0] HSEL_RIGHT = 2'b01;
    localparam logic [1:0] HSEL_LEFT  = 2'b10;

    assign sh_B = acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            dir_q      <= 1'b0;
            result     <= '0;
            ready      <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            sh_Hselect <= HSEL_PASS;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc   <= din;
                        cnt   <= amount;
                        dir_q <= dir;
                        ready <= 1'b0;
                        if (amount == '0) begin
                            result <= din;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            busy       <= 1'b1;
                            sh_Hselect <= dir ? HSEL_LEFT : HSEL_RIGHT;
                            state      <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc <= sh_H;
                    cnt <= cnt - 1'b1;
                    // cnt==1 means this edge applies the final step
                    if (cnt == CNT_W'(1)) begin
                        result     <= sh_H;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        sh_Hselect <= HSEL_PASS;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    ready      <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    sh_Hselect <= HSEL_PASS;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: table of shift operations plus hand-written sequences
// for start-while-busy and reset-abort, with a behavioural 1-bit shifter in the loop.
module tb_shift_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] din;
    logic             dir;
    logic [CNT_W-1:0] amount;
    logic             ready, busy, done;
    logic [WIDTH-1:0] result, sh_B, sh_H;
    logic [1:0]       sh_Hselect;

    int n_chk  = 0;
    int n_fail = 0;

    shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din), .dir(dir), .amount(amount),
        .ready(ready), .busy(busy), .done(done), .result(result),
        .sh_B(sh_B), .sh_Hselect(sh_Hselect), .sh_H(sh_H)
    );

    always #5 clk = ~clk;

    // Function-unit shifter: pass, logical right, logical left
    always_comb begin
        sh_H = sh_B;
        case (sh_Hselect)
            2'b01:   sh_H = sh_B >> 1;
            2'b10:   sh_H = sh_B << 1;
            default: sh_H = sh_B;
        endcase
    end

    typedef struct {
        logic [WIDTH-1:0] din;
        logic             dir;
        logic [CNT_W-1:0] amount;
        logic [WIDTH-1:0] exp_result;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op from IDLE and follow it through to the return to IDLE.
    task automatic run_op(input vec_t v, input int idx);
        int cycles;
        logic [1:0] exp_hsel;
        exp_hsel = v.dir ? 2'b10 : 2'b01;
        chk($sformatf("v%0d ready_before", idx), {31'b0, ready}, 32'd1);
        din = v.din; dir = v.dir; amount = v.amount; start = 1'b1;
        tick();
        start = 1'b0; din = '0; dir = ~v.dir; amount = '0;
        cycles = 0;
        while (!done && cycles < 40) begin
            chk($sformatf("v%0d busy", idx), {31'b0, busy}, 32'd1);
            chk($sformatf("v%0d hsel", idx), {30'b0, sh_Hselect}, {30'b0, exp_hsel});
            tick();
            cycles++;
        end
        chk($sformatf("v%0d done_seen", idx), {31'b0, done}, 32'd1);
        chk($sformatf("v%0d latency", idx), cycles, {27'b0, v.amount});
        chk($sformatf("v%0d result", idx), result, v.exp_result);
        chk($sformatf("v%0d hsel_done", idx), {30'b0, sh_Hselect}, 32'd0);
        chk($sformatf("v%0d busy_done", idx), {31'b0, busy}, 32'd0);
        tick();
        chk($sformatf("v%0d done_pulse", idx), {31'b0, done}, 32'd0);
        chk($sformatf("v%0d ready_after", idx), {31'b0, ready}, 32'd1);
        chk($sformatf("v%0d result_held", idx), result, v.exp_result);
    endtask

    initial begin
        int cycles;
        vecs[0] = '{32'h8000_0000, 1'b0, 5'd1,  32'h4000_0000};
        vecs[1] = '{32'h0000_000F, 1'b1, 5'd4,  32'h0000_00F0};
        vecs[2] = '{32'hDEAD_BEEF, 1'b0, 5'd0,  32'hDEAD_BEEF};
        vecs[3] = '{32'h0000_0001, 1'b1, 5'd31, 32'h8000_0000};
        vecs[4] = '{32'hFFFF_FFFF, 1'b0, 5'd31, 32'h0000_0001};
        vecs[5] = '{32'h1234_5678, 1'b1, 5'd8,  32'h3456_7800};
        vecs[6] = '{32'h1234_5678, 1'b0, 5'd4,  32'h0123_4567};

        rst = 1'b1; start = 1'b0; din = '0; dir = 1'b0; amount = '0;
        tick();
        tick();
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_hsel", {30'b0, sh_Hselect}, 32'd0);
        chk("rst_shB", sh_B, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) run_op(vecs[i], i);

        // start pulsed during SHIFT must be ignored
        din = 32'h0000_0001; dir = 1'b1; amount = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        din = 32'hAAAA_5555; dir = 1'b0; amount = 5'd2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_busy", {31'b0, busy}, 32'd1);
        chk("ign_hsel", {30'b0, sh_Hselect}, 32'd2);
        cycles = 3;
        while (!done && cycles < 40) begin
            tick();
            cycles++;
        end
        chk("ign_latency", cycles, 32'd8);
        chk("ign_result", result, 32'h0000_0100);
        tick();
        tick();
        chk("ign_no_requeue", {31'b0, busy}, 32'd0);
        chk("ign_ready", {31'b0, ready}, 32'd1);

        // reset in SHIFT cycle 3 aborts without a done pulse
        din = 32'h0000_0001; dir = 1'b1; amount = 5'd8; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("abort_busy_pre", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_ready", {31'b0, ready}, 32'd1);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_hsel", {30'b0, sh_Hselect}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", {31'b0, done | busy}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
